// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity modes and baud divider math.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Clocks per oversample tick, truncated; common to rx and tx.
  function automatic int uart_div(input int clk_hz, input int baud, input int os);
    return clk_hz / (baud * os);
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Holding-register side of the UART receiver: received frame, status flags and pop handshake.
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] rxOut;
  logic                 rxDone;
  logic                 rxValid;
  logic                 rxReady;
  logic                 rxParityErr;
  logic                 rxFrameErr;
  logic                 rxBreak;
  logic                 rxErr;
  logic                 rxOverrun;

  modport master (
    output rxOut, rxDone, rxValid, rxParityErr, rxFrameErr, rxBreak, rxErr, rxOverrun,
    input  rxReady
  );

  modport slave (
    input  rxOut, rxDone, rxValid, rxParityErr, rxFrameErr, rxBreak, rxErr, rxOverrun,
    output rxReady
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: down-counter reloading at terminal count, restartable to re-phase.
module uart_baud_tick #(
  parameter int DIV = 78
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int             CW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  RELOAD = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= RELOAD;
    end else if (restart || cnt == '0) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = (cnt == '0) && !restart;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: synchroniser, 3-sample majority vote, framing FSM and
// one-entry holding register with valid/ready pop and sticky overrun.
//
//  state     | meaning
//  ST_IDLE   | waiting for a 1->0 edge on an armed, enabled line
//  ST_START  | start bit; majority 1 means false start
//  ST_DATA   | payload bits, LSB first
//  ST_PARITY | optional parity bit
//  ST_STOP   | stop bit(s); frame completes at mid-sample of the last one
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rxEn,
  input  logic          rxIn,
  output logic          rxBusy,
  uart_rx_cfg_if.master rx
);

  localparam int DIV = uart_div(CLOCK_RATE, BAUD_RATE, OVERSAMPLE);
  localparam int IW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);

  localparam logic [IW-1:0] IDX_S0   = IW'(OVERSAMPLE/2 - 2);
  localparam logic [IW-1:0] IDX_S1   = IW'(OVERSAMPLE/2 - 1);
  localparam logic [IW-1:0] IDX_VOTE = IW'(OVERSAMPLE/2);
  localparam logic [IW-1:0] IDX_LAST = IW'(OVERSAMPLE - 1);

  rx_state_t state, state_nxt;

  logic [1:0]           sync;
  logic                 rx_s;
  logic                 armed;
  logic                 tick;
  logic [IW-1:0]        idx;
  logic                 s0, s1;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit;
  logic                 stop_zero, stop_one;

  logic start_det, vote_now, bit_end, vote, last_data, last_stop, frame_done;
  logic par_err, brk_now;

  logic [DATA_BITS-1:0] out_q;
  logic                 done_q, valid_q, perr_q, ferr_q, brk_q, ovr_q;

  assign rx_s = sync[1];

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (start_det),
    .tick    (tick)
  );

  // idx counts ticks elapsed in the current bit, so samples land at OS/2-1, OS/2, OS/2+1 ticks in.
  assign start_det  = (state == ST_IDLE) && rxEn && armed && !rx_s;
  assign vote_now   = tick && (state != ST_IDLE) && (idx == IDX_VOTE);
  assign bit_end    = tick && (state != ST_IDLE) && (idx == IDX_LAST);
  assign vote       = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  assign last_data  = (bit_cnt == BW'(DATA_BITS - 1));
  assign last_stop  = (bit_cnt == BW'(STOP_BITS - 1));
  assign frame_done = rxEn && (state == ST_STOP) && vote_now && last_stop;

  assign par_err = (PARITY != PAR_NONE) &&
                   (par_bit != ((^shift) ^ (PARITY == PAR_ODD)));
  assign brk_now = (shift == '0) && !par_bit && !stop_one && !vote;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (!rxEn) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (start_det) state_nxt = ST_START;
        ST_START: begin
          if (vote_now && vote) state_nxt = ST_IDLE;
          else if (bit_end)     state_nxt = ST_DATA;
        end
        ST_DATA: begin
          if (bit_end && last_data) begin
            if (PARITY != PAR_NONE) state_nxt = ST_PARITY;
            else                    state_nxt = ST_STOP;
          end
        end
        ST_PARITY: if (bit_end)    state_nxt = ST_STOP;
        ST_STOP:   if (frame_done) state_nxt = ST_IDLE;
        default:                   state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync      <= 2'b11;
      armed     <= 1'b0;
      idx       <= '0;
      s0        <= 1'b0;
      s1        <= 1'b0;
      bit_cnt   <= '0;
      shift     <= '0;
      par_bit   <= 1'b0;
      stop_zero <= 1'b0;
      stop_one  <= 1'b0;
    end else begin
      sync  <= {sync[0], rxIn};
      armed <= (state == ST_IDLE) && rxEn && rx_s;

      if (start_det)    idx <= '0;
      else if (bit_end) idx <= '0;
      else if (tick)    idx <= idx + 1'b1;

      if (tick && idx == IDX_S0) s0 <= rx_s;
      if (tick && idx == IDX_S1) s1 <= rx_s;

      if (state_nxt != state) bit_cnt <= '0;
      else if (bit_end)       bit_cnt <= bit_cnt + 1'b1;

      if (start_det) begin
        par_bit   <= 1'b0;
        stop_zero <= 1'b0;
        stop_one  <= 1'b0;
      end

      if (vote_now) begin
        case (state)
          ST_DATA:   shift   <= {vote, shift[DATA_BITS-1:1]};
          ST_PARITY: par_bit <= vote;
          ST_STOP: begin
            if (vote) stop_one  <= 1'b1;
            else      stop_zero <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // A load in the same cycle as a pop wins, so the pop is simply not applied.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_q   <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      done_q <= frame_done;
      if (frame_done) begin
        out_q   <= shift;
        perr_q  <= par_err;
        ferr_q  <= stop_zero | !vote;
        brk_q   <= brk_now;
        valid_q <= 1'b1;
        if (valid_q && !rx.rxReady) ovr_q <= 1'b1;
      end else if (valid_q && rx.rxReady) begin
        valid_q <= 1'b0;
        perr_q  <= 1'b0;
        ferr_q  <= 1'b0;
        brk_q   <= 1'b0;
      end
      if (!rxEn) ovr_q <= 1'b0;
    end
  end

  assign rxBusy         = (state != ST_IDLE);
  assign rx.rxOut       = out_q;
  assign rx.rxDone      = done_q;
  assign rx.rxValid     = valid_q;
  assign rx.rxParityErr = perr_q;
  assign rx.rxFrameErr  = ferr_q;
  assign rx.rxBreak     = brk_q;
  assign rx.rxErr       = perr_q | ferr_q;
  assign rx.rxOverrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: four receiver configurations driven in parallel, frames scoreboarded.
module tb_uart_rx_cfg;

  localparam int BIT      = 1248;
  localparam int BIT_SLOW = 1285;

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } exp_t;

  logic       clk = 1'b0;
  logic [3:0] rst_n;
  logic [3:0] en;
  logic [3:0] line;
  logic [3:0] ready;

  logic [3:0] busy_v, done_v, valid_v, perr_v, ferr_v, brk_v, err_v, ovr_v;
  logic [8:0] out_v [4];

  exp_t sb [4][$];
  int   done_cnt [4];
  int   checks = 0;
  int   fails  = 0;
  bit   mon_stop = 1'b0;

  always #5 clk = ~clk;

  uart_rx_cfg_if #(.DATA_BITS(8)) bus0 ();
  uart_rx_cfg_if #(.DATA_BITS(8)) bus1 ();
  uart_rx_cfg_if #(.DATA_BITS(9)) bus2 ();
  uart_rx_cfg_if #(.DATA_BITS(8)) bus3 ();

  uart_rx_cfg #(.PARITY(0)) u_8n1 (
    .clk(clk), .reset(rst_n[0]), .rxEn(en[0]), .rxIn(line[0]), .rxBusy(busy_v[0]), .rx(bus0));
  uart_rx_cfg #(.PARITY(2)) u_8e1 (
    .clk(clk), .reset(rst_n[1]), .rxEn(en[1]), .rxIn(line[1]), .rxBusy(busy_v[1]), .rx(bus1));
  uart_rx_cfg #(.DATA_BITS(9), .STOP_BITS(2)) u_9n2 (
    .clk(clk), .reset(rst_n[2]), .rxEn(en[2]), .rxIn(line[2]), .rxBusy(busy_v[2]), .rx(bus2));
  uart_rx_cfg u_8n1_b (
    .clk(clk), .reset(rst_n[3]), .rxEn(en[3]), .rxIn(line[3]), .rxBusy(busy_v[3]), .rx(bus3));

  assign bus0.rxReady = ready[0];
  assign bus1.rxReady = ready[1];
  assign bus2.rxReady = ready[2];
  assign bus3.rxReady = ready[3];

  assign out_v[0] = {1'b0, bus0.rxOut};
  assign out_v[1] = {1'b0, bus1.rxOut};
  assign out_v[2] = bus2.rxOut;
  assign out_v[3] = {1'b0, bus3.rxOut};
  assign done_v  = {bus3.rxDone,      bus2.rxDone,      bus1.rxDone,      bus0.rxDone};
  assign valid_v = {bus3.rxValid,     bus2.rxValid,     bus1.rxValid,     bus0.rxValid};
  assign perr_v  = {bus3.rxParityErr, bus2.rxParityErr, bus1.rxParityErr, bus0.rxParityErr};
  assign ferr_v  = {bus3.rxFrameErr,  bus2.rxFrameErr,  bus1.rxFrameErr,  bus0.rxFrameErr};
  assign brk_v   = {bus3.rxBreak,     bus2.rxBreak,     bus1.rxBreak,     bus0.rxBreak};
  assign err_v   = {bus3.rxErr,       bus2.rxErr,       bus1.rxErr,       bus0.rxErr};
  assign ovr_v   = {bus3.rxOverrun,   bus2.rxOverrun,   bus1.rxOverrun,   bus0.rxOverrun};

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int d, input logic [8:0] data, input logic perr,
                          input logic ferr, input logic brk);
    exp_t e;
    e.data = data;
    e.perr = perr;
    e.ferr = ferr;
    e.brk  = brk;
    sb[d].push_back(e);
  endtask

  // Drives frame bits [first, last) of start + data + parity + stops onto line d.
  task automatic send_frame(input int d, input logic [8:0] data, input int nbits,
                            input bit has_par, input logic par_bit, input int nstop,
                            input logic stop_val, input int bit_clk,
                            input int first, input int last);
    logic [15:0] fr;
    int n;
    fr = '1;
    fr[0] = 1'b0;
    n = 1;
    for (int i = 0; i < nbits; i++) begin fr[n] = data[i]; n++; end
    if (has_par) begin fr[n] = par_bit; n++; end
    for (int i = 0; i < nstop; i++) begin fr[n] = stop_val; n++; end
    for (int i = first; i < n && i < last; i++) begin
      line[d] = fr[i];
      hold(bit_clk);
    end
  endtask

  task automatic monitor;
    exp_t e;
    while (!mon_stop) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        if (done_v[d] === 1'b1) begin
          done_cnt[d]++;
          checks++;
          if (sb[d].size() == 0) begin
            fails++;
            $display("FAIL unexpected_done dut%0d got rxOut=%h want no frame", d, out_v[d]);
          end else begin
            e = sb[d].pop_front();
            if ({out_v[d], perr_v[d], ferr_v[d], brk_v[d], err_v[d], valid_v[d]} !==
                {e.data, e.perr, e.ferr, e.brk, e.perr | e.ferr, 1'b1}) begin
              fails++;
              $display("FAIL frame dut%0d got out=%h perr=%b ferr=%b brk=%b err=%b valid=%b want out=%h perr=%b ferr=%b brk=%b err=%b valid=1",
                       d, out_v[d], perr_v[d], ferr_v[d], brk_v[d], err_v[d], valid_v[d],
                       e.data, e.perr, e.ferr, e.brk, e.perr | e.ferr);
            end
          end
        end
      end
    end
  endtask

  task automatic test_reset;
    rst_n = '0;
    hold(3);
    for (int d = 0; d < 4; d++) begin
      checks++;
      if ({busy_v[d], done_v[d], valid_v[d], perr_v[d], ferr_v[d], brk_v[d], err_v[d],
           ovr_v[d], out_v[d]} !== 17'd0) begin
        fails++;
        $display("FAIL reset_state dut%0d got busy=%b done=%b valid=%b ovr=%b out=%h want all 0",
                 d, busy_v[d], done_v[d], valid_v[d], ovr_v[d], out_v[d]);
      end
    end
    rst_n = '1;
    hold(4);
  endtask

  task automatic test_8n1;
    int c0;
    ready[0] = 1'b1;
    c0 = done_cnt[0];
    push_exp(0, 9'h035, 1'b0, 1'b0, 1'b0);
    send_frame(0, 9'h035, 8, 1'b0, 1'b0, 1, 1'b1, BIT, 0, 3);
    checks++;
    if (busy_v[0] !== 1'b1) begin
      fails++; $display("FAIL busy_mid_8n1 got %b want 1", busy_v[0]);
    end
    send_frame(0, 9'h035, 8, 1'b0, 1'b0, 1, 1'b1, BIT, 3, 16);
    checks++;
    if (busy_v[0] !== 1'b0) begin
      fails++; $display("FAIL busy_after_stop got %b want 0", busy_v[0]);
    end
    checks++;
    if (done_cnt[0] !== c0 + 1) begin
      fails++; $display("FAIL done_count_8n1 got %0d want %0d", done_cnt[0], c0 + 1);
    end
    line[0] = 1'b1;
    hold(BIT / 2);
  endtask

  task automatic test_false_start;
    int c0;
    c0 = done_cnt[0];
    line[0] = 1'b0;
    hold(100);
    checks++;
    if (busy_v[0] !== 1'b1) begin
      fails++; $display("FAIL busy_glitch got %b want 1", busy_v[0]);
    end
    hold(100);
    line[0] = 1'b1;
    hold(2 * BIT);
    checks++;
    if (busy_v[0] !== 1'b0 || done_cnt[0] !== c0) begin
      fails++;
      $display("FAIL false_start got busy=%b done=%0d want busy=0 done=%0d", busy_v[0], done_cnt[0], c0);
    end
  endtask

  task automatic test_reset_mid;
    ready[0] = 1'b0;
    push_exp(0, 9'h096, 1'b0, 1'b0, 1'b0);
    send_frame(0, 9'h096, 8, 1'b0, 1'b0, 1, 1'b1, BIT, 0, 16);
    line[0] = 1'b1;
    hold(BIT / 2);
    checks++;
    if (valid_v[0] !== 1'b1 || out_v[0] !== 9'h096) begin
      fails++; $display("FAIL held_before_reset got valid=%b out=%h want valid=1 out=096", valid_v[0], out_v[0]);
    end
    send_frame(0, 9'h0C3, 8, 1'b0, 1'b0, 1, 1'b1, BIT, 0, 5);
    rst_n[0] = 1'b0;
    hold(1);
    checks++;
    if ({busy_v[0], done_v[0], valid_v[0], perr_v[0], ferr_v[0], brk_v[0], err_v[0],
         ovr_v[0], out_v[0]} !== 17'd0) begin
      fails++;
      $display("FAIL reset_mid_frame got busy=%b valid=%b out=%h want all 0", busy_v[0], valid_v[0], out_v[0]);
    end
    rst_n[0] = 1'b1;
    line[0] = 1'b1;
    hold(2 * BIT);
    ready[0] = 1'b1;
    push_exp(0, 9'h05A, 1'b0, 1'b0, 1'b0);
    send_frame(0, 9'h05A, 8, 1'b0, 1'b0, 1, 1'b1, BIT_SLOW, 0, 16);
    line[0] = 1'b1;
    hold(BIT);
  endtask

  task automatic test_parity;
    ready[1] = 1'b1;
    // 8'hA5 has four ones, so even parity requires a 0 parity bit.
    push_exp(1, 9'h0A5, 1'b1, 1'b0, 1'b0);
    send_frame(1, 9'h0A5, 8, 1'b1, 1'b1, 1, 1'b1, BIT, 0, 16);
    line[1] = 1'b1;
    hold(BIT / 2);
    push_exp(1, 9'h0A5, 1'b0, 1'b0, 1'b0);
    send_frame(1, 9'h0A5, 8, 1'b1, 1'b0, 1, 1'b1, BIT, 0, 16);
    line[1] = 1'b1;
    hold(BIT / 2);
  endtask

  task automatic test_break;
    push_exp(1, 9'h000, 1'b0, 1'b1, 1'b1);
    send_frame(1, 9'h000, 8, 1'b1, 1'b0, 1, 1'b0, BIT, 0, 16);
    line[1] = 1'b1;
    hold(BIT);
  endtask

  task automatic test_frame_err;
    ready[3] = 1'b1;
    push_exp(3, 9'h03C, 1'b0, 1'b1, 1'b0);
    send_frame(3, 9'h03C, 8, 1'b0, 1'b0, 1, 1'b0, BIT, 0, 16);
    line[3] = 1'b1;
    hold(BIT);
  endtask

  task automatic test_overrun;
    ready[3] = 1'b0;
    push_exp(3, 9'h011, 1'b0, 1'b0, 1'b0);
    send_frame(3, 9'h011, 8, 1'b0, 1'b0, 1, 1'b1, BIT, 0, 16);
    line[3] = 1'b1;
    hold(BIT / 2);
    push_exp(3, 9'h022, 1'b0, 1'b0, 1'b0);
    send_frame(3, 9'h022, 8, 1'b0, 1'b0, 1, 1'b1, BIT, 0, 16);
    line[3] = 1'b1;
    hold(BIT / 2);
    checks++;
    if (out_v[3] !== 9'h022 || valid_v[3] !== 1'b1 || ovr_v[3] !== 1'b1) begin
      fails++;
      $display("FAIL overrun_set got out=%h valid=%b ovr=%b want out=022 valid=1 ovr=1", out_v[3], valid_v[3], ovr_v[3]);
    end
    ready[3] = 1'b1;
    hold(1);
    ready[3] = 1'b0;
    checks++;
    if (valid_v[3] !== 1'b0 || ovr_v[3] !== 1'b1 || out_v[3] !== 9'h022) begin
      fails++;
      $display("FAIL pop_keeps_overrun got valid=%b ovr=%b out=%h want valid=0 ovr=1 out=022", valid_v[3], ovr_v[3], out_v[3]);
    end
    en[3] = 1'b0;
    hold(1);
    checks++;
    if (ovr_v[3] !== 1'b0) begin
      fails++; $display("FAIL overrun_clear got %b want 0", ovr_v[3]);
    end
    en[3] = 1'b1;
    hold(4);
  endtask

  task automatic test_9n2;
    int c0;
    ready[2] = 1'b0;
    push_exp(2, 9'h1C3, 1'b0, 1'b0, 1'b0);
    send_frame(2, 9'h1C3, 9, 1'b0, 1'b0, 2, 1'b1, BIT, 0, 16);
    line[2] = 1'b1;
    hold(BIT);
    c0 = done_cnt[2];
    // start bit plus data bits 0..3, then the receiver is disabled
    send_frame(2, 9'h0AA, 9, 1'b0, 1'b0, 2, 1'b1, BIT, 0, 5);
    en[2] = 1'b0;
    hold(1);
    checks++;
    if (busy_v[2] !== 1'b0) begin
      fails++; $display("FAIL abort_idle got busy=%b want 0", busy_v[2]);
    end
    line[2] = 1'b1;
    hold(100);
    en[2] = 1'b1;
    hold(2 * BIT);
    checks++;
    if (done_cnt[2] !== c0 || out_v[2] !== 9'h1C3 || valid_v[2] !== 1'b1) begin
      fails++;
      $display("FAIL abort_keeps_hold got done=%0d out=%h valid=%b want done=%0d out=1C3 valid=1",
               done_cnt[2], out_v[2], valid_v[2], c0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = '0;
    en    = '1;
    line  = '1;
    ready = '0;
    for (int d = 0; d < 4; d++) done_cnt[d] = 0;
    test_reset;
    fork
      monitor;
      begin
        fork
          begin test_8n1; test_false_start; test_reset_mid; end
          begin test_parity; test_break; end
          begin test_9n2; end
          begin test_frame_err; test_overrun; end
        join
        hold(10);
        mon_stop = 1'b1;
      end
    join
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (sb[d].size() != 0) begin
        fails++;
        $display("FAIL missing_frames dut%0d got %0d outstanding want 0", d, sb[d].size());
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
